// File: rtl/chunked_decrementer_if.sv
// chunked_decrementer_if: request/result bundle for the chunked decrementer.
// The master side issues operands; the slave side (the decrementer) returns
// the decremented value with a one-cycle valid pulse.
interface chunked_decrementer_if #(
  parameter int LEN = 30
);
  logic           start_in;
  logic [LEN-1:0] value_in;
  logic           ready_out;
  logic           valid_out;
  logic [LEN-1:0] result_out;
  logic           underflow_out;

  modport master (
    output start_in,
    output value_in,
    input  ready_out,
    input  valid_out,
    input  result_out,
    input  underflow_out
  );

  modport slave (
    input  start_in,
    input  value_in,
    output ready_out,
    output valid_out,
    output result_out,
    output underflow_out
  );
endinterface

// File: rtl/chunked_decrementer.sv
// chunked_decrementer: computes value_in - 1 (mod 2^LEN) over several clocks,
// rippling the borrow through one CHUNK-bit slice per cycle so no cycle holds
// a full-width borrow chain.
// Optional feature macro: DECREMENTER_EARLY_EXIT_EN. When defined, the
// operation finishes as soon as the borrow has been absorbed by a nonzero
// slice; the upper slices are untouched and therefore already correct.
module chunked_decrementer #(
  parameter int LEN   = 30,
  parameter int CHUNK = 8
) (
  input logic                  clk,
  input logic                  reset,
  chunked_decrementer_if.slave bus
);

  localparam int NCHUNK = (LEN + CHUNK - 1) / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          r_state;
  logic [LEN-1:0]  r_work;
  logic            r_borrow;
  logic [IDXW-1:0] r_idx;

  logic [31:0]     w_shamt;
  logic [CHUNK-1:0] w_slice;
  logic [CHUNK-1:0] w_newSlice;
  logic [LEN-1:0]  w_mask;
  logic [LEN-1:0]  w_nextWork;
  logic            w_newBorrow;
  logic            w_lastSlice;
  logic            w_exit;

  // Extract the current slice, apply the borrow and merge it back; bits of the
  // partial top slice that would lie above LEN-1 fall off the shift.
  always_comb begin
    w_shamt     = 32'(r_idx) * 32'(CHUNK);
    w_slice     = CHUNK'(r_work >> w_shamt);
    w_newSlice  = w_slice - CHUNK'(r_borrow);
    w_newBorrow = r_borrow & (w_slice == '0);
    w_mask      = LEN'({CHUNK{1'b1}}) << w_shamt;
    w_nextWork  = (r_work & ~w_mask) | ((LEN'(w_newSlice) << w_shamt) & w_mask);
    w_lastSlice = (r_idx == LAST_IDX);
`ifdef DECREMENTER_EARLY_EXIT_EN
    w_exit      = w_lastSlice | ~w_newBorrow;
`else
    w_exit      = w_lastSlice;
`endif
  end

  // Control FSM with registered handshake outputs; result and underflow are
  // only updated on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= IDLE;
      r_work            <= '0;
      r_borrow          <= 1'b0;
      r_idx             <= '0;
      bus.ready_out     <= 1'b1;
      bus.valid_out     <= 1'b0;
      bus.result_out    <= '0;
      bus.underflow_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          bus.valid_out <= 1'b0;
          if (bus.start_in) begin
            r_work        <= bus.value_in;
            r_borrow      <= 1'b1;
            r_idx         <= '0;
            bus.ready_out <= 1'b0;
            r_state       <= BUSY;
          end
        end
        BUSY: begin
          r_work   <= w_nextWork;
          r_borrow <= w_newBorrow;
          r_idx    <= r_idx + IDXW'(1);
          if (w_exit) begin
            bus.result_out    <= w_nextWork;
            bus.underflow_out <= w_newBorrow;
            bus.valid_out     <= 1'b1;
            r_state           <= DONE;
          end
        end
        DONE: begin
          bus.valid_out <= 1'b0;
          bus.ready_out <= 1'b1;
          r_state       <= IDLE;
        end
        default: begin
          bus.valid_out <= 1'b0;
          bus.ready_out <= 1'b1;
          r_state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_decrementer.sv
// tb_chunked_decrementer: directed and random checks of the chunked
// decrementer (LEN=30, CHUNK=8). Latency expectations follow
// DECREMENTER_EARLY_EXIT_EN when it is defined for the build.
module tb_chunked_decrementer;

  localparam int LEN = 30;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   validCount;
  int   expValids;
  logic [LEN-1:0] prevResult;

  chunked_decrementer_if #(.LEN(LEN)) bus ();

  chunked_decrementer #(
    .LEN  (LEN),
    .CHUNK(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every valid pulse seen on the falling edge.
  always @(negedge clk) begin
    if (bus.valid_out === 1'b1) validCount++;
  end

  // Hard stop in case something hangs.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Latency model: edges from the accepting edge (counted as 1) to valid.
  function automatic int expectedLatency(input logic [LEN-1:0] v);
`ifdef DECREMENTER_EARLY_EXIT_EN
    for (int s = 0; s < 4; s++) begin
      if (((v >> (8 * s)) & 30'hFF) != 0) return s + 2;
    end
    return 5;
`else
    return 5;
`endif
  endfunction

  // Issue one operand when ready and check the returned result and timing.
  task automatic applyStimulus(input string tag, input logic [LEN-1:0] v,
                               input int expLat);
    int   edges;
    int   waitCnt;
    logic seen;
    logic stable;
    logic [LEN-1:0] expRes;
    expRes  = v - 30'd1;
    waitCnt = 0;
    while (bus.ready_out !== 1'b1 && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput({tag, "_ready"}, 64'(bus.ready_out), 64'd1);
    bus.start_in = 1'b1;
    bus.value_in = v;
    edges  = 0;
    seen   = 1'b0;
    stable = 1'b1;
    while (!seen && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      bus.start_in = 1'b0;
      bus.value_in = LEN'($urandom);
      if (bus.valid_out === 1'b1) seen = 1'b1;
      else if (bus.result_out !== prevResult) stable = 1'b0;
    end
    checkOutput({tag, "_valid"}, 64'(seen), 64'd1);
    checkOutput({tag, "_latency"}, 64'(edges), 64'(expLat));
    checkOutput({tag, "_result"}, 64'(bus.result_out), 64'(expRes));
    checkOutput({tag, "_underflow"}, 64'(bus.underflow_out), 64'(v == '0));
    checkOutput({tag, "_stable"}, 64'(stable), 64'd1);
    prevResult = expRes;
    expValids++;
    @(posedge clk); #1;
    checkOutput({tag, "_pulse1"}, 64'(bus.valid_out), 64'd0);
  endtask

  // Main sequence: reset, directed vectors, protocol checks, random run.
  initial begin
    int   pulses;
    int   edges;
    logic [LEN-1:0] rv;
    checks       = 0;
    failures     = 0;
    validCount   = 0;
    expValids    = 0;
    prevResult   = '0;
    reset        = 1'b1;
    bus.start_in = 1'b0;
    bus.value_in = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_ready", 64'(bus.ready_out), 64'd1);
    checkOutput("rst_valid", 64'(bus.valid_out), 64'd0);
    checkOutput("rst_result", 64'(bus.result_out), 64'd0);
    checkOutput("rst_underflow", 64'(bus.underflow_out), 64'd0);

`ifdef DECREMENTER_EARLY_EXIT_EN
    applyStimulus("v5", 30'h0000_0005, 2);
    applyStimulus("v100", 30'h0000_0100, 3);
    applyStimulus("v0", 30'h0000_0000, 5);
    applyStimulus("vmax", 30'h3FFF_FFFF, 2);
    applyStimulus("vtop", 30'h2000_0000, 5);
`else
    applyStimulus("v5", 30'h0000_0005, 5);
    applyStimulus("v100", 30'h0000_0100, 5);
    applyStimulus("v0", 30'h0000_0000, 5);
    applyStimulus("vmax", 30'h3FFF_FFFF, 5);
    applyStimulus("vtop", 30'h2000_0000, 5);
`endif

    // A start pulse while busy must be ignored.
    bus.start_in = 1'b1;
    bus.value_in = 30'h0000_0005;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    @(posedge clk); #1;
    bus.start_in = 1'b1;
    bus.value_in = 30'h0000_0123;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      if (bus.valid_out === 1'b1) begin
        pulses++;
        checkOutput("ign_result", 64'(bus.result_out), 64'h4);
      end
      @(posedge clk); #1;
    end
    checkOutput("ign_pulses", 64'(pulses), 64'd1);
    expValids++;
    prevResult = 30'h4;

    // Reset in the middle of an operation aborts it cleanly.
    bus.start_in = 1'b1;
    bus.value_in = 30'h0000_0055;
    @(posedge clk); #1;
    bus.start_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_ready", 64'(bus.ready_out), 64'd1);
    checkOutput("abort_valid", 64'(bus.valid_out), 64'd0);
    checkOutput("abort_result", 64'(bus.result_out), 64'd0);
    checkOutput("abort_underflow", 64'(bus.underflow_out), 64'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.valid_out === 1'b1) pulses++;
    end
    checkOutput("abort_novalid", 64'(pulses), 64'd0);
    prevResult = '0;

    // Back-to-back random operands.
    for (int n = 0; n < 200; n++) begin
      rv = LEN'($urandom);
      if (n % 16 == 0) rv = rv & 30'h3FFF_FF00;
      if (n % 50 == 7) rv = '0;
      applyStimulus("rand", rv, expectedLatency(rv));
    end

    @(posedge clk); #1;
    checkOutput("valid_count", 64'(validCount), 64'(expValids));
    edges = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
